// File: rtl/mmult_seq.sv
// mmult_seq -- matrix-multiply instruction sequencer.
//
// Expands one decoded MMULT into IMULTN, (n-1) x IMACN and a closing RESMAC.
// Before each multiply step the element is fetched from local RAM through
// mtx_mreq/datack.
//
// Ports:
//   clk, reset        clock, asynchronous active-high reset
//   go                MMULT decoded (only sampled in IDLE)
//   instruction       MMULT word: [9:5] Rs vector base, [4:0] Rn destination
//   gpu_din           config write data for mtxawr / mtxcwr
//   mtxawr, mtxcwr    write matrix base / control (size, row/column mode)
//   datack            RAM acknowledge for the current request
//   mtx_mreq, mtxaddr RAM read request and element word address
//   mtx_wait          request outstanding in REQ without acknowledge
//   mtx_atomic        sequence in progress
//   mtx_dover         pulse alongside RESMAC
//   multsel           multiplier operand B taken from RAM data
//   sysins, sysser    generated instruction and its valid strobe
//   sys_hi            use the high half of the source register
//
// Build option: define MMULT_PREFETCH_EN to keep the next element's request
// up during ISSUE. This gives one element per cycle when the RAM has no wait states.
module mmult_seq #(
    parameter int ADDR_W = 10,
    parameter int N_W    = 4,
    parameter int MIN_N  = 3,
    parameter int REG_W  = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              go,
    input  logic [15:0]       instruction,
    input  logic [31:0]       gpu_din,
    input  logic              mtxawr,
    input  logic              mtxcwr,
    input  logic              datack,
    output logic              mtx_mreq,
    output logic [ADDR_W-1:0] mtxaddr,
    output logic              mtx_wait,
    output logic              mtx_atomic,
    output logic              mtx_dover,
    output logic              multsel,
    output logic [15:0]       sysins,
    output logic              sysser,
    output logic              sys_hi
);
    localparam logic [5:0] OP_IMULTN = 6'd18;
    localparam logic [5:0] OP_RESMAC = 6'd19;
    localparam logic [5:0] OP_IMACN  = 6'd20;

    typedef enum logic [1:0] {IDLE, REQ, ISSUE, FINAL} state_t;

    state_t              state;
    logic [ADDR_W-1:0]   mtxa;
    logic [N_W-1:0]      size;
    logic                mode;

    // Sequence shadows: config writes during a run only affect the next one.
    logic [N_W-1:0]      n_sh;
    logic [ADDR_W-1:0]   stride_sh;
    logic [REG_W-1:0]    rs_sh;
    logic [4:0]          rn_sh;
    logic [N_W-1:0]      step;
    logic [ADDR_W-1:0]   addr;

    logic [N_W-1:0]      n_cfg;
    logic [ADDR_W-1:0]   stride_cfg;
    logic [N_W-1:0]      step_nxt;
    logic [ADDR_W-1:0]   addr_nxt;
    logic                last;
    logic                nxt_last;
    logic                unused_bits;

    assign n_cfg      = (size < N_W'(MIN_N)) ? N_W'(MIN_N) : size;
    assign stride_cfg = mode ? ADDR_W'(n_cfg) : ADDR_W'(1);
    assign step_nxt   = step + N_W'(1);
    assign addr_nxt   = addr + stride_sh;
    assign last       = (step == n_sh - N_W'(1));
    assign nxt_last   = (step_nxt == n_sh - N_W'(1));

    // The stall depends on datack in the same cycle, so it cannot be registered.
    assign mtx_wait   = (state == REQ) && !datack;

    assign unused_bits = ^{instruction[15:10], gpu_din};

    // Two consecutive steps share one source register: the high half comes first.
    function automatic logic [15:0] issue_word(input logic [N_W-1:0]   s,
                                               input logic [REG_W-1:0] rs,
                                               input logic [4:0]       rn);
        logic [REG_W-1:0] src;
        src = rs + REG_W'(s >> 1);
        return {(s == '0) ? OP_IMULTN : OP_IMACN, 5'(src), rn};
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mtxa <= '0;
            size <= N_W'(MIN_N);
            mode <= 1'b0;
        end else begin
            if (mtxawr) mtxa <= gpu_din[ADDR_W+1:2];
            if (mtxcwr) begin
                size <= gpu_din[N_W-1:0];
                mode <= gpu_din[N_W];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            n_sh       <= N_W'(MIN_N);
            stride_sh  <= ADDR_W'(1);
            rs_sh      <= '0;
            rn_sh      <= '0;
            step       <= '0;
            addr       <= '0;
            mtx_mreq   <= 1'b0;
            mtxaddr    <= '0;
            mtx_atomic <= 1'b0;
            mtx_dover  <= 1'b0;
            multsel    <= 1'b0;
            sysins     <= '0;
            sysser     <= 1'b0;
            sys_hi     <= 1'b0;
        end else begin
            case (state)
                IDLE: if (go) begin
                    state      <= REQ;
                    n_sh       <= n_cfg;
                    stride_sh  <= stride_cfg;
                    rs_sh      <= REG_W'(instruction[9:5]);
                    rn_sh      <= instruction[4:0];
                    step       <= '0;
                    addr       <= mtxa;
                    mtx_mreq   <= 1'b1;
                    mtxaddr    <= mtxa;
                    mtx_atomic <= 1'b1;
                end
                REQ: if (datack) begin
                    state   <= ISSUE;
                    sysser  <= 1'b1;
                    multsel <= 1'b1;
                    sysins  <= issue_word(step, rs_sh, rn_sh);
                    sys_hi  <= ~step[0];
`ifdef MMULT_PREFETCH_EN
                    mtx_mreq <= !last;
                    mtxaddr  <= addr_nxt;
`else
                    mtx_mreq <= 1'b0;
`endif
                end
                ISSUE: begin
                    step <= step_nxt;
                    addr <= addr_nxt;
                    if (last) begin
                        state     <= FINAL;
                        mtx_mreq  <= 1'b0;
                        multsel   <= 1'b0;
                        sysser    <= 1'b1;
                        sysins    <= {OP_RESMAC, 5'd0, rn_sh};
                        sys_hi    <= 1'b0;
                        mtx_dover <= 1'b1;
                    end
`ifdef MMULT_PREFETCH_EN
                    // The next element was acknowledged during this ISSUE, so its step issues immediately.
                    else if (datack) begin
                        state    <= ISSUE;
                        sysser   <= 1'b1;
                        multsel  <= 1'b1;
                        sysins   <= issue_word(step_nxt, rs_sh, rn_sh);
                        sys_hi   <= ~step_nxt[0];
                        mtx_mreq <= !nxt_last;
                        mtxaddr  <= addr_nxt + stride_sh;
                    end
`endif
                    else begin
                        state    <= REQ;
                        sysser   <= 1'b0;
                        multsel  <= 1'b0;
                        sysins   <= '0;
                        sys_hi   <= 1'b0;
                        mtx_mreq <= 1'b1;
                        mtxaddr  <= addr_nxt;
                    end
                end
                FINAL: begin
                    state      <= IDLE;
                    sysser     <= 1'b0;
                    sysins     <= '0;
                    mtx_dover  <= 1'b0;
                    mtx_atomic <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/mmult_seq.md
Name: mmult_seq

Overview:
- Parametrised successor to the GPU systolic matrix-multiply sequencer.
- Turns one decoded MMULT instruction into N multiply-accumulate steps: IMULTN, then (N-1)x IMACN, then RESMAC.
- Fetches one matrix element per step from local RAM through a mreq/datack handshake.
- Adds configurable matrix size/address width, row- or column-major stride, and shadowed config registers.

Parameters:
- ADDR_W, 10, word-address width of mtxaddr (byte address bits [ADDR_W+1:2]).
- N_W, 4, width of matrix-size field.
- MIN_N, 3, smallest legal matrix size; smaller programmed values are clamped to MIN_N.
- REG_W, 5, register index width.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- go  in  1  one-cycle pulse: MMULT decoded; ignored unless idle.
- instruction  in  16  MMULT opcode word; [9:5]=Rs vector base register, [4:0]=Rn destination.
- gpu_din  in  32  config write data.
- mtxawr  in  1  write matrix base address: mtxa <= gpu_din[ADDR_W+1:2].
- mtxcwr  in  1  write control: size <= gpu_din[N_W-1:0], mode <= gpu_din[N_W] (0 row, 1 column).
- datack  in  1  RAM data acknowledge for the current request.
- mtx_mreq  out  1  RAM read request.
- mtxaddr  out  ADDR_W  word address of the requested element.
- mtx_wait  out  1  pipeline stall: request outstanding without ack.
- mtx_atomic  out  1  sequence in progress; inhibits interrupts.
- mtx_dover  out  1  one-cycle pulse with RESMAC.
- multsel  out  1  ALU multiplier operand B comes from RAM data.
- sysins  out  16  generated instruction: [15:10] opcode, [9:5] source register, [4:0] Rn.
- sysser  out  1  sysins valid this cycle.
- sys_hi  out  1  use the high 16 bits of the source register (1) or the low 16 bits (0).

Behaviour:
Reset:
- All outputs 0; FSM in IDLE.
- mtxa=0, size=MIN_N, mode=0.
- Reset mid-sequence aborts immediately; no RESMAC is issued.

Config:
- mtxawr and mtxcwr update the architectural registers at any time.
- On go, the values are copied into shadows (base, n, stride, Rs, Rn). Writes during a sequence affect only the next sequence.
- If mtxawr and mtxcwr are asserted together, both update.
- n = max(size, MIN_N).
- stride = 1 in row mode, n in column mode.
- Address arithmetic is modulo 2^ADDR_W and wraps silently.

FSM:
- IDLE: go -> REQ. step=0, addr=base, mtx_atomic=1 from the next cycle.
- REQ:
  - mtx_mreq=1, mtxaddr=addr.
  - mtx_wait = ~datack.
  - datack -> ISSUE; otherwise hold (request held stable).
- ISSUE (1 cycle):
  - sysser=1, multsel=1.
  - sysins opcode = 18 (IMULTN) if step==0, else 20 (IMACN).
  - sysins[9:5] = Rs + (step>>1), modulo 2^REG_W.
  - sys_hi = ~step[0].
  - addr += stride; step++.
  - -> FINAL if step==n-1, else REQ.
- FINAL (1 cycle):
  - sysser=1, multsel=0, opcode 19 (RESMAC), sysins[4:0]=Rn, mtx_dover=1.
  - -> IDLE; mtx_atomic falls with the exit.

Edge cases:
- datack outside REQ is ignored.
- go while not IDLE is ignored.
- go in the same cycle as mtxcwr: the old value is shadowed.

Latency (no RAM wait states):
- 2 cycles per element, plus 1 cycle for RESMAC.
- go to mtx_dover = 2n+1 cycles.

Optional Feature:
MMULT_PREFETCH_EN
- With the macro: during ISSUE, mtx_mreq stays asserted for the next element's address (when step < n-1).
  - If datack arrives in ISSUE, the next ISSUE follows directly; otherwise the FSM goes to REQ.
  - Throughput is 1 element per cycle with zero-wait RAM: go to mtx_dover = n+2.
- Without the macro: the strict REQ/ISSUE alternation above; mtx_mreq=0 in ISSUE.
- sysins sequence and addresses are identical in both builds.

Test Plan:
- Row mode, mtxa=0x100, size=4, Rs=8, Rn=3, datack tied 1:
  - mtxaddr 0x100, 0x101, 0x102, 0x103.
  - sysins opcodes 18, 20, 20, 20, 19.
  - Source regs 8, 8, 9, 9; sys_hi 1, 0, 1, 0.
  - mtx_dover at cycle 9 (cycle 6 with prefetch).
- Column mode, size=3, mtxa=0x3FE (ADDR_W=10): addresses 0x3FE, 0x001, 0x004 (wrap checked).
- size=1 programmed: sequence runs with n=3 (three elements, then RESMAC).
- datack delayed 3 cycles on element 2:
  - mtx_wait=1 for exactly 3 cycles; mtxaddr stable; sysser stays 0 until ack.
- mtxcwr size=8 and a second go mid-sequence (size=4 active):
  - Current run completes with 4 elements; second go ignored; the next go runs 8.
- reset asserted during step 2:
  - All outputs 0 asynchronously; no RESMAC.
  - After release, go restarts from step 0 with the retained register values reset to defaults.
